// File: rtl/issue_pkg.sv
// Shared op-field layout and source-operand wakeup for the issue logic
// (used by both the single-entry slot and the multi-entry issue_queue).
`ifndef RENAMED_OP_SZ
`define RENAMED_OP_SZ 40
`endif

package issue_pkg;

  localparam int OP_W       = `RENAMED_OP_SZ;
  localparam int TAG_W      = 5;
  localparam int TAG_LSB    = 13;
  localparam int TAG_STRIDE = 5;
  localparam int RDY_LSB    = 4;
  localparam int TAG_BASE   = 2;
  localparam int MAX_SRC    = 4;
  localparam int MAX_PREGS  = 1 << TAG_W;

  typedef enum logic [1:0] {
    SEL_HOLD  = 2'd0,
    SEL_SHIFT = 2'd1,
    SEL_NEW   = 2'd2
  } slot_sel_e;

  // Sets the ready bit of every source whose physical tag has been written.
  // Tags below TAG_BASE are not register-backed and never change readiness.
  function automatic logic [OP_W-1:0] wakeup(input logic [OP_W-1:0]      op,
                                             input logic [MAX_PREGS-1:0] done,
                                             input int                   num_src,
                                             input int                   num_pregs);
    logic [OP_W-1:0]  res;
    logic [TAG_W-1:0] tag;
    int               idx;
    res = op;
    for (int i = 0; i < MAX_SRC; i++) begin
      tag = op[TAG_LSB + TAG_STRIDE*i +: TAG_W];
      idx = int'(tag) - TAG_BASE;
      if (i < num_src && idx >= 0 && idx < num_pregs && done[idx[TAG_W-1:0]])
        res[RDY_LSB + i] = 1'b1;
    end
    return res;
  endfunction

endpackage

// File: rtl/issue_slot.sv
// One issue-queue entry: storage, combinational wakeup and eligibility, and the
// hold / shift-down / load-new input mux used by the collapsing array.
module issue_slot
  import issue_pkg::*;
#(
  parameter int INST_WIDTH = OP_W,
  parameter int NUM_SRC    = 4,
  parameter int NUM_PREGS  = 30
) (
  input  logic                  clk,
  input  logic [1:0]            sel,
  input  logic [INST_WIDTH-1:0] shift_in,
  input  logic [INST_WIDTH-1:0] new_in,
  input  logic [NUM_PREGS-1:0]  done_flags,
  output logic [INST_WIDTH-1:0] woken,
  output logic                  eligible
);

  logic [INST_WIDTH-1:0] entry_q, entry_d;

  always_comb begin
    woken    = INST_WIDTH'(wakeup(OP_W'(entry_q), MAX_PREGS'(done_flags), NUM_SRC, NUM_PREGS));
    eligible = &woken[RDY_LSB +: NUM_SRC];
  end

  // Holding rewrites the woken value, so ready bits accumulate every cycle.
  always_comb begin
    entry_d = woken;
    case (sel)
      SEL_SHIFT: entry_d = shift_in;
      SEL_NEW:   entry_d = new_in;
      default:   entry_d = woken;
    endcase
  end

  always_ff @(posedge clk) begin
    entry_q <= entry_d;
  end

endmodule

// File: rtl/issue_queue.sv
// Age-ordered collapsing issue queue: wakes sources from done_flags and issues
// the oldest eligible op. Define ISSUE_QUEUE_BYPASS_EN for same-cycle bypass.
`ifndef RENAMED_OP_SZ
`define RENAMED_OP_SZ 40
`endif

module issue_queue
  import issue_pkg::*;
#(
  parameter int INST_WIDTH = `RENAMED_OP_SZ,
  parameter int DEPTH      = 8,
  parameter int NUM_SRC    = 4,
  parameter int NUM_PREGS  = 30
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic [NUM_PREGS-1:0]       done_flags,
  input  logic [INST_WIDTH-1:0]      instr_in,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [INST_WIDTH-1:0]      instr_out,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int IW = $clog2(DEPTH);

  logic [CW-1:0]         count_q, count_d, base;
  logic [INST_WIDTH-1:0] woken [DEPTH];
  logic [DEPTH-1:0]      elig;
  logic [1:0]            sel [DEPTH];
  logic [INST_WIDTH-1:0] in_woken;
  logic                  sel_found, deq, enq, byp_take;
  logic [IW-1:0]         sel_idx;

  assign in_woken = INST_WIDTH'(wakeup(OP_W'(instr_in), MAX_PREGS'(done_flags), NUM_SRC, NUM_PREGS));
  assign in_ready = (count_q != CW'(DEPTH));
  assign count    = count_q;

  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    logic [INST_WIDTH-1:0] shift_src;
    if (i < DEPTH-1) begin : g_up
      assign shift_src = woken[i+1];
    end else begin : g_top
      assign shift_src = woken[i];
    end
    issue_slot #(
      .INST_WIDTH (INST_WIDTH),
      .NUM_SRC    (NUM_SRC),
      .NUM_PREGS  (NUM_PREGS)
    ) u_slot (
      .clk        (clk),
      .sel        (sel[i]),
      .shift_in   (shift_src),
      .new_in     (in_woken),
      .done_flags (done_flags),
      .woken      (woken[i]),
      .eligible   (elig[i])
    );
  end

  // Oldest-first priority encoder over the valid entries.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (elig[i] && (CW'(i) < count_q)) begin
        sel_found = 1'b1;
        sel_idx   = IW'(i);
      end
    end
  end

  always_comb begin
    out_valid = sel_found;
    instr_out = woken[sel_idx];
    byp_take  = 1'b0;
`ifdef ISSUE_QUEUE_BYPASS_EN
    if (!sel_found && in_valid && in_ready && (&in_woken[RDY_LSB +: NUM_SRC])) begin
      out_valid = 1'b1;
      instr_out = in_woken;
      byp_take  = out_ready;
    end
`endif
    deq  = sel_found && out_ready;
    enq  = in_valid && in_ready && !byp_take;
    // After a dequeue compacts the array, the tail slot is count-1.
    base = deq ? (count_q - CW'(1)) : count_q;
    for (int i = 0; i < DEPTH; i++) begin
      sel[i] = SEL_HOLD;
      if (enq && (CW'(i) == base))
        sel[i] = SEL_NEW;
      else if (deq && (IW'(i) >= sel_idx))
        sel[i] = SEL_SHIFT;
    end
    count_d = count_q + CW'(enq) - CW'(deq);
    if (rst || flush)
      count_d = '0;
  end

  always_ff @(posedge clk) begin
    count_q <= count_d;
  end

endmodule

// File: tb/tb_issue_queue.sv
// Scenario-driven bench for issue_queue with an expected-issue scoreboard.
module tb_issue_queue;

  localparam int W     = 40;
  localparam int DEPTH = 8;
  localparam int CW    = 4;

  logic          clk = 1'b0;
  logic          rst, flush, in_valid, out_ready, in_ready, out_valid;
  logic [29:0]   done_flags;
  logic [W-1:0]  instr_in, instr_out;
  logic [CW-1:0] count;

  logic [W-1:0]  exp_q[$];
  logic [W-1:0]  exp_op;
  int            checks   = 0;
  int            failures = 0;

  always #5 clk = ~clk;

  issue_queue #(
    .INST_WIDTH (W),
    .DEPTH      (DEPTH),
    .NUM_SRC    (4),
    .NUM_PREGS  (30)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .done_flags (done_flags),
    .instr_in   (instr_in),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .instr_out  (instr_out),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .count      (count)
  );

  function automatic logic [W-1:0] mk(input int id, input int t0, input int t1,
                                      input int t2, input int t3, input logic [3:0] rdy);
    logic [W-1:0] op;
    logic [6:0]   idv;
    idv        = 7'(id);
    op         = '0;
    op[39:33]  = idv;
    op[3:0]    = idv[3:0];
    op[12:8]   = idv[4:0];
    op[17:13]  = 5'(t0);
    op[22:18]  = 5'(t1);
    op[27:23]  = 5'(t2);
    op[32:28]  = 5'(t3);
    op[7:4]    = rdy;
    return op;
  endfunction

  // Reference wakeup: ready bit i set when its tag maps to a written register.
  function automatic logic [W-1:0] model_w(input logic [W-1:0] op, input logic [29:0] done);
    logic [W-1:0] r;
    int           t;
    r = op;
    for (int i = 0; i < 4; i++) begin
      t = int'(op[13 + 5*i +: 5]);
      if (t >= 2 && (t - 2) < 30)
        if (done[t - 2]) r[4 + i] = 1'b1;
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic enq(input logic [W-1:0] op);
    in_valid = 1'b1;
    instr_in = op;
    #2;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    done_flags = '0; instr_in = '0;
    tick(); tick();
    rst = 1'b0;
    #2;
    checks++;
    if (count !== 4'd0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset: count=%0d in_ready=%b out_valid=%b, expected 0/1/0", count, in_ready, out_valid);
    end
  endtask

  task automatic test_wakeup();
    logic [W-1:0] op;
    op = mk(1, 3, 4, 0, 1, 4'b1100);
    out_ready = 1'b0;
    enq(op);
    #2;
    checks++;
    if (count !== 4'd1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL wakeup_wait: count=%0d out_valid=%b, expected 1/0", count, out_valid);
    end
    done_flags[1] = 1'b1;
    done_flags[2] = 1'b1;
    exp_q.push_back(model_w(op, done_flags));
    #1;
    checks++;
    exp_op = exp_q.pop_front();
    if (out_valid !== 1'b1 || instr_out !== exp_op || instr_out[7:4] !== 4'hF) begin
      failures++;
      $display("FAIL wakeup_same_cycle: valid=%b out=%h, expected 1/%h", out_valid, instr_out, exp_op);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    done_flags = '0;
    #2;
    checks++;
    if (count !== 4'd0) begin
      failures++;
      $display("FAIL wakeup_drain: count=%0d expected 0", count);
    end
  endtask

  task automatic test_out_of_order();
    logic [W-1:0] a, b;
    a = mk(2, 5, 0, 0, 0, 4'b1110);
    b = mk(3, 0, 0, 0, 0, 4'b1111);
    out_ready = 1'b0;
    enq(a);
    enq(b);
    #2;
    checks++;
    if (count !== 4'd2) begin
      failures++;
      $display("FAIL ooo_count2: count=%0d expected 2", count);
    end
    exp_q.push_back(model_w(b, done_flags));
    out_ready = 1'b1;
    #1;
    checks++;
    exp_op = exp_q.pop_front();
    if (out_valid !== 1'b1 || instr_out !== exp_op) begin
      failures++;
      $display("FAIL ooo_issue_b: valid=%b out=%h, expected 1/%h", out_valid, instr_out, exp_op);
    end
    tick();
    #1;
    checks++;
    if (count !== 4'd1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL ooo_count1: count=%0d out_valid=%b, expected 1/0", count, out_valid);
    end
    done_flags[3] = 1'b1;
    exp_q.push_back(model_w(a, done_flags));
    #1;
    checks++;
    exp_op = exp_q.pop_front();
    if (out_valid !== 1'b1 || instr_out !== exp_op) begin
      failures++;
      $display("FAIL ooo_issue_a: valid=%b out=%h, expected 1/%h", out_valid, instr_out, exp_op);
    end
    tick();
    out_ready = 1'b0;
    done_flags = '0;
    #1;
    checks++;
    if (count !== 4'd0) begin
      failures++;
      $display("FAIL ooo_count0: count=%0d expected 0", count);
    end
  endtask

  task automatic test_full();
    logic [W-1:0] op;
    logic [29:0]  done_future;
    done_future = 30'(1) << 29;
    out_ready = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      op = (k == 0) ? mk(16, 0, 0, 0, 0, 4'hF) : mk(16 + k, 31, 0, 0, 0, 4'hE);
      checks++;
      if (in_ready !== 1'b1 || count !== CW'(k)) begin
        failures++;
        $display("FAIL fill_%0d: in_ready=%b count=%0d, expected 1/%0d", k, in_ready, count, k);
      end
      exp_q.push_back(model_w(op, done_future));
      enq(op);
    end
    #2;
    checks++;
    if (count !== 4'd8 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL full: count=%0d in_ready=%b, expected 8/0", count, in_ready);
    end
    in_valid = 1'b1;
    instr_in = mk(40, 0, 0, 0, 0, 4'hF);
    out_ready = 1'b1;
    #1;
    checks++;
    exp_op = exp_q.pop_front();
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || instr_out !== exp_op) begin
      failures++;
      $display("FAIL full_issue: in_ready=%b valid=%b out=%h, expected 0/1/%h", in_ready, out_valid, instr_out, exp_op);
    end
    tick();
    in_valid = 1'b0;
    #1;
    checks++;
    if (count !== 4'd7) begin
      failures++;
      $display("FAIL full_no_enq: count=%0d expected 7", count);
    end
    done_flags = done_future;
    for (int k = 1; k < DEPTH; k++) begin
      #1;
      checks++;
      exp_op = exp_q.pop_front();
      if (out_valid !== 1'b1 || instr_out !== exp_op) begin
        failures++;
        $display("FAIL drain_%0d: valid=%b out=%h, expected 1/%h", k, out_valid, instr_out, exp_op);
      end
      tick();
    end
    out_ready = 1'b0;
    done_flags = '0;
    #1;
    checks++;
    if (count !== 4'd0) begin
      failures++;
      $display("FAIL drain_empty: count=%0d expected 0", count);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] o0, o1, o2, nw;
    logic [29:0]  done_future;
    done_future = 30'(1) << 29;
    o0 = mk(48, 31, 0, 0, 0, 4'hE);
    o1 = mk(49, 0, 0, 0, 0, 4'hF);
    o2 = mk(50, 31, 0, 0, 0, 4'hE);
    nw = mk(51, 31, 0, 0, 0, 4'hE);
    out_ready = 1'b0;
    enq(o0); enq(o1); enq(o2);
    #2;
    checks++;
    if (count !== 4'd3) begin
      failures++;
      $display("FAIL b2b_count3: count=%0d expected 3", count);
    end
    exp_q.push_back(model_w(o1, done_flags));
    in_valid = 1'b1;
    instr_in = nw;
    out_ready = 1'b1;
    #1;
    checks++;
    exp_op = exp_q.pop_front();
    if (in_ready !== 1'b1 || out_valid !== 1'b1 || instr_out !== exp_op) begin
      failures++;
      $display("FAIL b2b_issue_mid: in_ready=%b valid=%b out=%h, expected 1/1/%h", in_ready, out_valid, instr_out, exp_op);
    end
    tick();
    in_valid = 1'b0;
    #1;
    checks++;
    if (count !== 4'd3) begin
      failures++;
      $display("FAIL b2b_count_hold: count=%0d expected 3", count);
    end
    done_flags = done_future;
    exp_q.push_back(model_w(o0, done_future));
    exp_q.push_back(model_w(o2, done_future));
    exp_q.push_back(model_w(nw, done_future));
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      exp_op = exp_q.pop_front();
      if (out_valid !== 1'b1 || instr_out !== exp_op) begin
        failures++;
        $display("FAIL b2b_order_%0d: valid=%b out=%h, expected 1/%h", k, out_valid, instr_out, exp_op);
      end
      tick();
    end
    out_ready = 1'b0;
    done_flags = '0;
    #1;
    checks++;
    if (count !== 4'd0) begin
      failures++;
      $display("FAIL b2b_empty: count=%0d expected 0", count);
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++)
      enq(mk(64 + k, 1, 0, 0, 0, 4'hE));
    done_flags = '1;
    #2;
    checks++;
    if (count !== 4'd5 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL below_base_tag: count=%0d out_valid=%b, expected 5/0", count, out_valid);
    end
    out_ready = 1'b1;
    flush = 1'b1;
    in_valid = 1'b1;
    instr_in = mk(70, 0, 0, 0, 0, 4'hF);
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    done_flags = '0;
    #1;
    checks++;
    if (count !== 4'd0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL flush: count=%0d out_valid=%b, expected 0/0", count, out_valid);
    end
    enq(mk(71, 31, 0, 0, 0, 4'hE));
    rst = 1'b1;
    flush = 1'b1;
    in_valid = 1'b1;
    instr_in = mk(72, 31, 0, 0, 0, 4'hE);
    tick();
    rst = 1'b0;
    flush = 1'b0;
    in_valid = 1'b0;
    #1;
    checks++;
    if (count !== 4'd0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL rst_over_enq: count=%0d in_ready=%b, expected 0/1", count, in_ready);
    end
  endtask

  task automatic test_bypass();
    logic [W-1:0] bp;
    bp = mk(80, 0, 0, 0, 0, 4'hF);
    exp_q.push_back(model_w(bp, done_flags));
    out_ready = 1'b1;
    in_valid = 1'b1;
    instr_in = bp;
    #2;
`ifdef ISSUE_QUEUE_BYPASS_EN
    checks++;
    exp_op = exp_q.pop_front();
    if (out_valid !== 1'b1 || instr_out !== exp_op) begin
      failures++;
      $display("FAIL bypass_same_cycle: valid=%b out=%h, expected 1/%h", out_valid, instr_out, exp_op);
    end
    tick();
    in_valid = 1'b0;
    #1;
    checks++;
    if (count !== 4'd0) begin
      failures++;
      $display("FAIL bypass_no_enq: count=%0d expected 0", count);
    end
`else
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL no_bypass_latency: out_valid=%b expected 0", out_valid);
    end
    tick();
    in_valid = 1'b0;
    #1;
    checks++;
    exp_op = exp_q.pop_front();
    if (count !== 4'd1 || out_valid !== 1'b1 || instr_out !== exp_op) begin
      failures++;
      $display("FAIL next_cycle_issue: count=%0d valid=%b out=%h, expected 1/1/%h", count, out_valid, instr_out, exp_op);
    end
    tick();
    #1;
    checks++;
    if (count !== 4'd0) begin
      failures++;
      $display("FAIL next_cycle_drain: count=%0d expected 0", count);
    end
`endif
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_wakeup();
    test_out_of_order();
    test_full();
    test_back_to_back();
    test_flush();
    test_bypass();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_leftover: entries=%0d expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/issue_queue.md
Name: issue_queue

Overview:
- Parametrised multi-entry successor to the single-slot issue entry, sitting between rename and the execution-unit dispatch port.
- Holds up to DEPTH renamed ops in age order.
- Each cycle, wakes up source operands from the physical-register done flags. An op becomes eligible only when all its source ready bits are set.
- Issues the oldest eligible op through a valid/ready handshake, so ops may issue out of order within the queue.

Parameters:
- INST_WIDTH, `RENAMED_OP_SZ, renamed-op width.
- DEPTH, 8, number of entries (>=2).
- NUM_SRC, 4, source operands per op.
- TAG_W, 5, physical-tag width.
- TAG_LSB, 13, bit position of source tag 0.
- TAG_STRIDE, 5, bit distance between consecutive source tags.
- RDY_LSB, 4, bit position of ready bit 0; ready bit i sits at RDY_LSB+i.
- NUM_PREGS, 30, width of done_flags.
- TAG_BASE, 2, tag that maps to done_flags[0].

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- flush  in  1  synchronous clear of all entries (mispredict)
- done_flags  in  NUM_PREGS  bit k=1: physical reg k+TAG_BASE has been written
- instr_in  in  INST_WIDTH  op from rename
- in_valid  in  1  instr_in valid
- in_ready  out  1  queue can accept
- instr_out  out  INST_WIDTH  op to execute, ready bits updated
- out_valid  out  1  instr_out is eligible
- out_ready  in  1  consumer accepts
- count  out  $clog2(DEPTH+1)  occupied entries

Behaviour:
- Wakeup function W(op), combinational. For each source i, let t = op[TAG_LSB+TAG_STRIDE*i +: TAG_W].
  - If t >= TAG_BASE, t-TAG_BASE < NUM_PREGS and done_flags[t-TAG_BASE]=1, set op[RDY_LSB+i].
  - Otherwise the bit is unchanged. Tags below TAG_BASE never change readiness.
  - Ready bits are sticky: never cleared once set.
- Eligible(op) = all NUM_SRC ready bits of W(op) are 1.
- Storage is a collapsing array. Entry 0 is oldest; entries 0..count-1 are valid.
- Every cycle, each valid entry is rewritten with W(entry). This applies whether or not a handshake occurs.
- Select: the lowest-index valid entry with Eligible=1.
  - out_valid=1 when such an entry exists.
  - instr_out = W(selected entry); otherwise instr_out is don't-care.
- in_ready = (count != DEPTH). It does not depend on out_ready, so there is no comb path out_ready->in_ready.
- Enqueue (in_valid&in_ready): W(instr_in) is written behind the last valid entry.
- Dequeue (out_valid&out_ready): the selected entry is removed; all entries above it shift down by one in the same cycle, preserving age order.
- Simultaneous enqueue and dequeue:
  - The new op lands at index count-1 after compaction; count is unchanged.
  - This is legal when full only if in_ready was already 1, i.e. a full queue cannot accept in the same cycle it issues.
- Minimum latency: enqueue cycle N, issue no earlier than cycle N+1.
- Full: in_ready=0; issue continues. Empty: out_valid=0 (without the optional feature).
- A done flag rising in cycle N makes a waiting op eligible in cycle N (wakeup is combinational on the stored entry).
- flush or rst: count<=0 on the next edge. Any in-flight enqueue/dequeue that cycle is discarded. rst has priority over flush.
- Reset values: count=0, in_ready=1, out_valid=0, instr_out=X. Entry contents are X.

Optional Feature:
- Macro: ISSUE_QUEUE_BYPASS_EN.
- Defined: when no stored entry is eligible and in_valid=1 with Eligible(instr_in):
  - out_valid=1 and instr_out=W(instr_in) in the same cycle.
  - If out_ready=1, the op is consumed and not enqueued.
  - If out_ready=0, it is enqueued normally.
  - Stored eligible ops always have priority over bypass.
  - This adds a comb path instr_in/in_valid->out_valid.
- Undefined: no bypass; minimum latency is 1 cycle.

Decomposition:
- Package issue_pkg holds the field-position constants (TAG_LSB, TAG_STRIDE, RDY_LSB, TAG_BASE) and the wakeup function. Both this block and the legacy single entry share it.
- One sub-module, issue_slot: per-entry storage, wakeup and eligible output, with a shift-in mux. issue_queue instantiates DEPTH of them plus the oldest-first priority encoder and count logic.

Test Plan:
- Reset, then enqueue op with tags {3,4,0,1}, ready bits 0, done_flags=0 -> out_valid=0, count=1. Raise done_flags[1] and done_flags[2] -> out_valid=1 that cycle, instr_out ready bits 4..7 set.
- Enqueue A (tags waiting on reg 5) then B (all ready); raise done_flags[3] later -> B issues first, then A. count goes 2->1->0.
- Fill 8 entries with out_ready=0 -> in_ready=0 at count=8. An in_valid with out_ready=1 issue cycle -> no enqueue, count=7.
- count=3, entry 1 issues while a new op enqueues -> count stays 3. Order becomes old0, old2, new.
- count=5, assert flush with in_valid=1 -> next cycle count=0, out_valid=0.
- With ISSUE_QUEUE_BYPASS_EN, empty queue, fully ready op with out_ready=1 -> out_valid same cycle, count stays 0. Without the macro -> issues next cycle.
